// File: rtl/sccb_target_if.sv
// sccb_target_if: SCCB bus levels plus the target's register-write and status outputs.
interface sccb_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       busy;
  logic       addr_match;
  modport master (output scl_in, sda_in, input sda_oe, wr_addr, wr_data, wr_valid, busy, addr_match);
  modport slave  (input scl_in, sda_in, output sda_oe, wr_addr, wr_data, wr_valid, busy, addr_match);
endinterface

// File: rtl/sccb_target.sv
// sccb_target: oversampling write-only SCCB/I2C target that ACKs frames addressed to DEV_ADDR
// and emits one wr_valid strobe for each data byte, at an auto-incrementing register address.
module sccb_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input logic           meg25,
  input logic           rst_n,
  sccb_target_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, DEV, DEV_ACK, REG, REG_ACK, DAT, DAT_ACK, IGNORE} state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_dly_q, sda_dly_q;
  logic [7:0]             shift_q, shift_d, addr_q, addr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   sda_oe_q, sda_oe_d, wr_valid_q, wr_valid_d, busy_q, busy_d, match_q, match_d;
  logic                   scl_s, sda_s, scl_rise, scl_fall, start, stop, collecting, in_ack;
  logic [7:0]             shift_in;
  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_dly_q;
  assign scl_fall   = ~scl_s & scl_dly_q;
  assign start      = scl_s & sda_dly_q & ~sda_s;
  assign stop       = scl_s & ~sda_dly_q & sda_s;
  assign collecting = (state_q == DEV) || (state_q == REG) || (state_q == DAT);
  assign in_ack     = (state_q == DEV_ACK) || (state_q == REG_ACK) || (state_q == DAT_ACK);
  assign shift_in   = {shift_q[6:0], sda_s};
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    cnt_d      = cnt_q;
    sda_oe_d   = sda_oe_q;
    wr_valid_d = 1'b0;
    busy_d     = busy_q;
    match_d    = match_q;
    if (stop) begin
      state_d  = IDLE;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      match_d  = 1'b0;
    end else if (start) begin
      state_d  = DEV;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
      match_d  = 1'b0;
    end else if (collecting && scl_rise && cnt_q != 4'd8) begin
      shift_d = shift_in;
      cnt_d   = cnt_q + 4'd1;
      // The device byte is judged on its 8th bit; a miss drops out before the ACK slot.
      if (state_q == DEV && cnt_q == 4'd7) begin
        match_d = shift_in == {DEV_ADDR, 1'b0};
        state_d = shift_in == {DEV_ADDR, 1'b0} ? DEV : IGNORE;
      end
    end else if (collecting && scl_fall && cnt_q == 4'd8) begin
      cnt_d    = 4'd0;
      sda_oe_d = 1'b1;
      state_d  = state_q == DEV ? DEV_ACK : state_q == REG ? REG_ACK : DAT_ACK;
      addr_d   = state_q == REG ? shift_q : state_q == DAT ? addr_q + 8'd1 : addr_q;
      if (state_q == DAT) begin
        wr_addr_d  = addr_q;
        wr_data_d  = shift_q;
        wr_valid_d = 1'b1;
      end
    end else if (in_ack && scl_fall) begin
      sda_oe_d = 1'b0;
      state_d  = state_q == DEV_ACK ? REG : DAT;
    end
  end
  always_ff @(posedge meg25 or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      addr_q     <= 8'd0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      cnt_q      <= 4'd0;
      sda_oe_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
      state_q    <= state_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cnt_q      <= cnt_d;
      sda_oe_q   <= sda_oe_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
      match_q    <= match_d;
    end
  end
  assign bus.sda_oe     = sda_oe_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.busy       = busy_q;
  assign bus.addr_match = match_q;
endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: directed frame table plus hand-written repeated-START, truncation and reset sequences.
module tb_sccb_target;
  logic meg25 = 1'b0;
  logic rst_n = 1'b0;
  always #5 meg25 = ~meg25;
  sccb_target_if bus();
  sccb_target #(.DEV_ADDR(7'h21), .SYNC_STAGES(2)) dut (.meg25(meg25), .rst_n(rst_n), .bus(bus));
  typedef struct {
    int              nb;
    logic [3:0][7:0] b;
    logic [3:0]      ack;
    int              ns;
    logic [7:0]      a0, d0, a1, d1;
    logic            m;
  } vec_t;
  vec_t       vecs[6];
  int         tests = 0;
  int         fails = 0;
  int         nstrobe = 0;
  logic [7:0] sa[8], sd[8];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge meg25);
  endtask
  always @(negedge meg25) begin
    if (rst_n && bus.wr_valid) begin
      chk("oe_with_strobe", {31'd0, bus.sda_oe}, 32'd1);
      if (nstrobe < 8) begin
        sa[nstrobe] = bus.wr_addr;
        sd[nstrobe] = bus.wr_data;
      end
      nstrobe++;
    end
  end
  task automatic bit_out(input logic b);
    wait_cyc(3);
    bus.sda_in = b;
    wait_cyc(3);
    bus.scl_in = 1'b1;
    wait_cyc(6);
    bus.scl_in = 1'b0;
  endtask
  task automatic start_c;
    bus.sda_in = 1'b1;
    wait_cyc(3);
    bus.scl_in = 1'b1;
    wait_cyc(6);
    bus.sda_in = 1'b0;
    wait_cyc(6);
    bus.scl_in = 1'b0;
  endtask
  task automatic stop_c;
    wait_cyc(3);
    bus.sda_in = 1'b0;
    wait_cyc(3);
    bus.scl_in = 1'b1;
    wait_cyc(6);
    bus.sda_in = 1'b1;
    wait_cyc(6);
  endtask
  task automatic byte_out(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) bit_out(v[i]);
    wait_cyc(3);
    bus.sda_in = 1'b1;
    wait_cyc(3);
    bus.scl_in = 1'b1;
    wait_cyc(3);
    ack = bus.sda_oe;
    wait_cyc(3);
    bus.scl_in = 1'b0;
  endtask
  task automatic run_vec(input int k, input vec_t v);
    logic [3:0] acks;
    logic       a;
    acks    = 4'd0;
    nstrobe = 0;
    start_c();
    chk($sformatf("v%0d_busy_start", k), {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < v.nb; i++) begin
      byte_out(v.b[i], a);
      acks[i] = a;
    end
    chk($sformatf("v%0d_acks", k), {28'd0, acks}, {28'd0, v.ack});
    chk($sformatf("v%0d_match", k), {31'd0, bus.addr_match}, {31'd0, v.m});
    chk($sformatf("v%0d_busy_pre_stop", k), {31'd0, bus.busy}, 32'd1);
    stop_c();
    chk($sformatf("v%0d_busy_post_stop", k), {31'd0, bus.busy}, 32'd0);
    chk($sformatf("v%0d_match_post_stop", k), {31'd0, bus.addr_match}, 32'd0);
    chk($sformatf("v%0d_oe_post_stop", k), {31'd0, bus.sda_oe}, 32'd0);
    chk($sformatf("v%0d_nstrobe", k), nstrobe, v.ns);
    if (v.ns >= 1) chk($sformatf("v%0d_s0", k), {16'd0, sa[0], sd[0]}, {16'd0, v.a0, v.d0});
    if (v.ns >= 2) chk($sformatf("v%0d_s1", k), {16'd0, sa[1], sd[1]}, {16'd0, v.a1, v.d1});
  endtask
  initial begin
    logic a;
    vecs[0] = '{3, {8'h00, 8'h80, 8'h12, 8'h42}, 4'b0111, 1, 8'h12, 8'h80, 8'h00, 8'h00, 1'b1};
    vecs[1] = '{4, {8'h5A, 8'hA5, 8'hFF, 8'h42}, 4'b1111, 2, 8'hFF, 8'hA5, 8'h00, 8'h5A, 1'b1};
    vecs[2] = '{3, {8'h00, 8'hFF, 8'hFF, 8'hFF}, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{2, {8'h00, 8'h00, 8'h10, 8'h43}, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{3, {8'h00, 8'h02, 8'h01, 8'h40}, 4'b0000, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{4, {8'h3C, 8'hC3, 8'h7F, 8'h42}, 4'b1111, 2, 8'h7F, 8'hC3, 8'h80, 8'h3C, 1'b1};
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    wait_cyc(3);
    chk("rst_outputs", {bus.sda_oe, bus.wr_valid, bus.busy, bus.addr_match, bus.wr_addr, bus.wr_data},
        {4'b0000, 16'h0000});
    rst_n = 1'b1;
    wait_cyc(4);
    for (int k = 0; k < 6; k++) run_vec(k, vecs[k]);
    // Repeated START abandons the first frame before any data byte.
    nstrobe = 0;
    start_c();
    byte_out(8'h42, a);
    byte_out(8'h12, a);
    start_c();
    chk("rs_match_cleared", {31'd0, bus.addr_match}, 32'd0);
    byte_out(8'h42, a);
    byte_out(8'h34, a);
    byte_out(8'h56, a);
    chk("rs_last_ack", {31'd0, a}, 32'd1);
    stop_c();
    chk("rs_nstrobe", nstrobe, 1);
    chk("rs_strobe", {16'd0, sa[0], sd[0]}, 32'h3456);
    // STOP after 5 data bits: nothing written, previous write held.
    nstrobe = 0;
    start_c();
    byte_out(8'h42, a);
    byte_out(8'h12, a);
    for (int i = 7; i >= 3; i--) bit_out(i[0]);
    stop_c();
    chk("trunc_nstrobe", nstrobe, 0);
    chk("trunc_hold", {16'd0, bus.wr_addr, bus.wr_data}, 32'h3456);
    chk("trunc_busy", {31'd0, bus.busy}, 32'd0);
    // Reset while the target is driving the device-byte ACK.
    nstrobe = 0;
    start_c();
    for (int i = 7; i >= 0; i--) bit_out(8'h42 >> i);
    wait_cyc(6);
    chk("ack_before_rst", {31'd0, bus.sda_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {bus.sda_oe, bus.busy, bus.addr_match, bus.wr_valid}, 4'b0000);
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(4);
    run_vec(6, '{3, {8'h00, 8'h02, 8'h01, 8'h42}, 4'b0111, 1, 8'h01, 8'h02, 8'h00, 8'h00, 1'b1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- SCCB/I2C write-only target (responder), clocked by meg25.
- Oversamples the bus, detects START/STOP, and ACKs frames addressed to DEV_ADDR.
- Frames are device address, register address, then data bytes; each data byte produces a register write strobe.
- Used as the camera-side model opposite the i2c config master, and as a bus monitor for checking configuration sequences.

Parameters:
- DEV_ADDR, 7'h21, 7-bit target address; write byte is {DEV_ADDR,1'b0} = 8'h42.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (min 2).

Ports:
- meg25  input  1  system clock, 25 MHz.
- rst_n  input  1  asynchronous active-low reset.
- scl_in  input  1  bus SCL level (async).
- sda_in  input  1  bus SDA level (async).
- sda_oe  output  1  1 = pull SDA low (open-drain enable); 0 = release.
- wr_addr  output  8  register address of the current write.
- wr_data  output  8  data byte of the current write.
- wr_valid  output  1  one-cycle write strobe.
- busy  output  1  high from START to STOP while a frame is in progress.
- addr_match  output  1  high once the device byte has matched, until STOP or START.

Behaviour:
- Reset: all outputs 0; state IDLE; bit counter 0; synchronizers preset to 1 (idle bus).
- Synchronize scl and sda through SYNC_STAGES flops.
- Edges are computed from the synced value vs. its 1-cycle-delayed copy.
- Bus timing: SCL high and low phases are each ≥4 meg25 cycles.
- START: synced sda falls while synced scl = 1.
  - From any state (including repeated START): go to DEV, bit count 0, sda_oe 0, addr_match 0, busy 1.
- STOP: synced sda rises while synced scl = 1.
  - From any state: go to IDLE; sda_oe 0, busy 0, addr_match 0 on the next edge. No wr_valid is generated.
- Data bits are shifted MSB-first on each synced scl rising edge in DEV/REG/DAT states. The 8th rising edge completes the byte.
- States:
  - IDLE: wait for START.
  - DEV: collect 8 bits.
    - Byte == {DEV_ADDR,0}: addr_match = 1; on the next scl falling edge go to DEV_ACK.
    - Any other byte, including R/W = 1: go to IGNORE; no ACK.
  - DEV_ACK: sda_oe = 1 from the cycle after the scl falling edge that ended bit 8, until the next scl falling edge (ACK clock end); then sda_oe = 0 and go to REG.
  - REG: collect 8 bits into an address register. On the next falling edge go to REG_ACK (ACK as in DEV_ACK); then go to DAT.
  - DAT: collect 8 bits. On the falling edge ending bit 8:
    - wr_data = byte and wr_addr = current address.
    - wr_valid = 1 for exactly one cycle, in the same cycle sda_oe rises.
    - Then go to DAT_ACK; after ACK return to DAT.
  - Each subsequent data byte uses address+1, wrapping 8'hFF→8'h00.
  - IGNORE: sda_oe held 0; leave only on START or STOP.
- Simultaneous edges: START/STOP detection takes priority over bit shifting in the same cycle.
- A START/STOP arriving in any ACK state releases sda_oe immediately (next edge).
- A frame truncated mid-byte is discarded: no wr_valid, and wr_addr/wr_data keep their last values.
- wr_addr/wr_data hold their values between strobes.
- sda_oe changes only while synced scl = 0, except on STOP/START/reset release.
- rst_n low mid-frame: all outputs 0 asynchronously. The next transaction requires a fresh START.

Test Plan:
- Frame 42,12,80 then STOP → ACK (sda_oe=1) in 3 ACK slots; one wr_valid with wr_addr=8'h12, wr_data=8'h80; busy 1→0 after STOP.
- Frame 42,FF,A5,5A → two strobes: (FF,A5) then (00,5A) on address wrap; all 4 bytes ACKed.
- All-ones frame FF,FF,FF (address 7F, R/W=1) → sda_oe never asserts, no wr_valid, addr_match 0, busy 1 until STOP.
- Frame 42,12, then repeated START, then 42,34,56 → no strobe for the first frame; one strobe (34,56).
- STOP after 5 bits of the data byte in 42,12,xx → no wr_valid; state IDLE; wr_addr/wr_data unchanged from the prior write.
- rst_n pulled low during DEV_ACK (sda_oe=1) → sda_oe=0 within the reset assertion; following frame 42,01,02 is written correctly.
